// File: rtl/permute_controller.sv
// Sequencer for the file permutation datapath: walks files x lines in READ/LOAD/WRITE triplets.
// Optional hold input enabled by defining PERMUTE_CTRL_STALL_EN.
module permute_controller #(
    parameter int NUM_FILES  = 24,
    parameter int NUM_LINES  = 64,
    parameter int FIRST_FILE = 0
) (
    input  logic       clk,
    input  logic       rst,
`ifdef PERMUTE_CTRL_STALL_EN
    input  logic       stall,
`endif
    input  logic       start,
    output logic       read_file,
    output logic       write_reg,
    output logic       write_file,
    output logic [9:0] file_index,
    output logic [5:0] line_index,
    output logic       busy,
    output logic       done
);

    localparam logic [9:0] FIRST_IDX = 10'(FIRST_FILE);
    localparam logic [9:0] LAST_FILE = 10'(FIRST_FILE + NUM_FILES - 1);
    localparam logic [5:0] LAST_LINE = 6'(NUM_LINES - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LOAD,
        WRITE,
        DONE
    } state_t;

    state_t state;
    logic   read_q;
    logic   load_q;
    logic   write_q;
    logic   start_q;
    logic   hold;

`ifdef PERMUTE_CTRL_STALL_EN
    // Strobe registers keep their value while held; the mask makes the strobe
    // reappear exactly once on the first released cycle.
    assign hold       = stall & busy;
    assign read_file  = read_q & ~stall;
    assign write_reg  = load_q & ~stall;
    assign write_file = write_q & ~stall;
`else
    assign hold       = 1'b0;
    assign read_file  = read_q;
    assign write_reg  = load_q;
    assign write_file = write_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            read_q     <= 1'b0;
            load_q     <= 1'b0;
            write_q    <= 1'b0;
            start_q    <= 1'b0;
            file_index <= '0;
            line_index <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            start_q <= start;
            if (!hold) begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state      <= READ;
                            file_index <= FIRST_IDX;
                            line_index <= '0;
                            read_q     <= 1'b1;
                            busy       <= 1'b1;
                        end
                    end
                    READ: begin
                        state  <= LOAD;
                        read_q <= 1'b0;
                        load_q <= 1'b1;
                    end
                    LOAD: begin
                        state   <= WRITE;
                        load_q  <= 1'b0;
                        write_q <= 1'b1;
                    end
                    WRITE: begin
                        write_q <= 1'b0;
                        if (line_index < LAST_LINE) begin
                            state      <= READ;
                            line_index <= line_index + 6'd1;
                            read_q     <= 1'b1;
                        end else if (file_index < LAST_FILE) begin
                            state      <= READ;
                            line_index <= '0;
                            file_index <= file_index + 10'd1;
                            read_q     <= 1'b1;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    DONE: begin
                        done <= 1'b0;
                        // Only a start that was already high before DONE (held
                        // continuously) chains a new run; a fresh pulse here is dropped.
                        if (start && start_q) begin
                            state      <= READ;
                            file_index <= FIRST_IDX;
                            line_index <= '0;
                            read_q     <= 1'b1;
                            busy       <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        read_q  <= 1'b0;
                        load_q  <= 1'b0;
                        write_q <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_permute_controller.sv
// Directed bench for permute_controller with NUM_FILES=2, NUM_LINES=4, FIRST_FILE=5.
module tb_permute_controller;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stall;
    logic       read_file;
    logic       write_reg;
    logic       write_file;
    logic [9:0] file_index;
    logic [5:0] line_index;
    logic       busy;
    logic       done;

    int checks;
    int failures;

    permute_controller #(
        .NUM_FILES (2),
        .NUM_LINES (4),
        .FIRST_FILE(5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef PERMUTE_CTRL_STALL_EN
        .stall     (stall),
`endif
        .start     (start),
        .read_file (read_file),
        .write_reg (write_reg),
        .write_file(write_file),
        .file_index(file_index),
        .line_index(line_index),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] f;
        logic [5:0] l;
    } vec_t;

    vec_t       seq[8];
    logic [2:0] phase[3];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] outs();
        return {11'b0, read_file, write_reg, write_file, busy, done, file_index, line_index};
    endfunction

    function automatic logic [31:0] pack(input logic [2:0] s, input logic b, input logic d,
                                         input logic [9:0] f, input logic [5:0] l);
        return {11'b0, s, b, d, f, l};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic run_count(input int pulse_at, output int nbusy, output int ndone);
        nbusy = 0;
        ndone = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (busy) nbusy++;
            if (done) ndone++;
            start = (c == pulse_at);
            tick();
        end
        start = 1'b0;
    endtask

    initial begin
        int nb;
        int nd;
        int nw;
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        start    = 1'b0;
        stall    = 1'b0;

        seq[0] = '{10'd5, 6'd0}; seq[1] = '{10'd5, 6'd1};
        seq[2] = '{10'd5, 6'd2}; seq[3] = '{10'd5, 6'd3};
        seq[4] = '{10'd6, 6'd0}; seq[5] = '{10'd6, 6'd1};
        seq[6] = '{10'd6, 6'd2}; seq[7] = '{10'd6, 6'd3};
        phase[0] = 3'b100; phase[1] = 3'b010; phase[2] = 3'b001;

        // Reset state, before and after clock edges
        #1;
        check("reset_async", outs(), 32'd0);
        tick();
        tick();
        check("reset_held", outs(), 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("idle_no_start_%0d", i), outs(), 32'd0);
        end

        // Full run, triplet by triplet
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            for (int p = 0; p < 3; p++) begin
                check($sformatf("run_t%0d", 3 * i + p), outs(),
                      pack(phase[p], 1'b1, 1'b0, seq[i].f, seq[i].l));
                tick();
            end
        end
        check("run_done", outs(), pack(3'b000, 1'b0, 1'b1, 10'd6, 6'd3));
        tick();
        check("run_idle0", outs(), pack(3'b000, 1'b0, 1'b0, 10'd6, 6'd3));
        tick();
        check("run_idle1", outs(), pack(3'b000, 1'b0, 1'b0, 10'd6, 6'd3));

        // Start re-pulsed mid-run is ignored
        run_count(7, nb, nd);
        check("repulse_busy", 32'(nb), 32'd24);
        check("repulse_done", 32'(nd), 32'd1);

        // Fresh start pulse landing in DONE is ignored
        run_count(24, nb, nd);
        check("done_pulse_busy", 32'(nb), 32'd24);
        check("done_pulse_done", 32'(nd), 32'd1);
        check("done_pulse_idle", outs(), pack(3'b000, 1'b0, 1'b0, 10'd6, 6'd3));

        // Asynchronous abort at (6,2)
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < 19; t++) tick();
        check("abort_pre", outs(), pack(3'b010, 1'b1, 1'b0, 10'd6, 6'd2));
        #2;
        rst = 1'b0;
        #1;
        check("abort_async", outs(), 32'd0);
        tick();
        tick();
        check("abort_held", outs(), 32'd0);
        rst = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("abort_restart", outs(), pack(3'b100, 1'b1, 1'b0, 10'd5, 6'd0));
        for (int t = 0; t < 24; t++) tick();
        check("abort_rerun_done", outs(), pack(3'b000, 1'b0, 1'b1, 10'd6, 6'd3));
        tick();

        // Start held high: back-to-back runs, one DONE cycle apart
        start = 1'b1;
        tick();
        for (int c = 0; c < 60; c++) begin
            check($sformatf("held_c%0d", c), {30'd0, busy, done},
                  {30'd0, ((c < 24) || (c >= 25 && c < 49)), (c == 24 || c == 49)});
            if (c == 25)
                check("held_second_start", outs(), pack(3'b100, 1'b1, 1'b0, 10'd5, 6'd0));
            if (c == 48) start = 1'b0;
            tick();
        end

`ifdef PERMUTE_CTRL_STALL_EN
        // Stall for three cycles in LOAD
        start = 1'b1;
        tick();
        start = 1'b0;
        nb = 1;
        tick();
        for (int k = 0; k < 3; k++) begin
            stall = 1'b1;
            #1;
            check($sformatf("stall_hold_%0d", k), outs(), pack(3'b000, 1'b1, 1'b0, 10'd5, 6'd0));
            nb++;
            tick();
        end
        stall = 1'b0;
        #1;
        check("stall_release", outs(), pack(3'b010, 1'b1, 1'b0, 10'd5, 6'd0));
        nb++;
        nw = 1;
        tick();
        for (int c = 0; c < 60; c++) begin
            if (done) break;
            if (busy) nb++;
            if (write_reg) nw++;
            tick();
        end
        check("stall_busy_total", 32'(nb), 32'd27);
        check("stall_write_reg_count", 32'(nw), 32'd8);
        check("stall_end", outs(), pack(3'b000, 1'b0, 1'b1, 10'd6, 6'd3));
        tick();
`else
        nw = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/permute_controller.md
PERMUTE_CONTROLLER -- requirements
Module: permute_controller

Interface
REQ-001 Parameter NUM_FILES, default 24, number of files processed per run (1..1024).
REQ-002 Parameter NUM_LINES, default 64, lines per file (1..64).
REQ-003 Parameter FIRST_FILE, default 0, file_index of the first file in a run; FIRST_FILE+NUM_FILES-1 SHALL NOT exceed 1023.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  run request, sampled only in IDLE.
REQ-007 read_file  output  1  datapath file-read strobe.
REQ-008 write_reg  output  1  datapath 25-bit register load strobe.
REQ-009 write_file  output  1  datapath permuted-word write strobe.
REQ-010 file_index  output  10  current file.
REQ-011 line_index  output  6  current line.
REQ-012 busy  output  1  high while a run is in progress.
REQ-013 done  output  1  one-cycle pulse at run completion.

Function
REQ-014 The FSM SHALL have states IDLE, READ, LOAD, WRITE and DONE.
REQ-015 IDLE: with start=1 at a clock edge, go to READ, file_index<=FIRST_FILE, line_index<=0; otherwise stay in IDLE.
REQ-016 READ: read_file=1 for exactly one cycle, then go to LOAD.
REQ-017 LOAD: write_reg=1 for exactly one cycle, then go to WRITE.
REQ-018 WRITE: write_file=1 for exactly one cycle; the next state depends on the line and file position.
REQ-019 WRITE, line_index<NUM_LINES-1: line_index increments; go to READ.
REQ-020 WRITE, last line, file not last: line_index<=0, file_index increments; go to READ.
REQ-021 WRITE, last line of last file: go to DONE; the indices hold their values.
REQ-022 DONE: done=1 for one cycle, then IDLE; the indices are held for the output to be read.
REQ-023 Each line SHALL take exactly 3 cycles; a run SHALL have busy=1 for exactly 3*NUM_FILES*NUM_LINES cycles.
REQ-024 busy=1 in READ, LOAD and WRITE only.
REQ-025 read_file, write_reg and write_file SHALL be mutually exclusive and registered (glitch-free).
REQ-026 start while busy or in DONE SHALL be ignored and not queued.
REQ-027 start held high continuously SHALL begin a new run on the cycle after DONE.
REQ-028 file_index and line_index SHALL be stable throughout each READ/LOAD/WRITE triplet.
REQ-029 The counters SHALL never exceed NUM_LINES-1 or FIRST_FILE+NUM_FILES-1; there is no wrap-around beyond these bounds.

Reset
REQ-030 rst=0 SHALL force IDLE immediately, without waiting for clk.
REQ-031 On reset, all outputs SHALL be 0: strobes, file_index, line_index, busy, done.
REQ-032 A reset mid-run SHALL abort the run with no done pulse; the next run SHALL restart from FIRST_FILE, line 0.
REQ-033 After rst rises, the first start SHALL be accepted on the first following clock edge.

Configuration
REQ-034 Macro PERMUTE_CTRL_STALL_EN, when defined, SHALL add port "stall  input  1  hold request".
REQ-035 With the macro defined and stall=1 in READ, LOAD or WRITE, the FSM and counters SHALL hold.
REQ-036 During such a stall, all strobes SHALL be 0; the strobe for the held state SHALL re-assert once, on the first cycle with stall=0.
REQ-037 stall SHALL have no effect in IDLE or DONE.
REQ-038 Without the macro, the port SHALL be absent and behaviour SHALL equal stall=0.

Verification
REQ-039 Scenario: NUM_FILES=2, NUM_LINES=4, FIRST_FILE=5, start pulse -> busy for 24 cycles; (file,line) sequence (5,0)..(5,3),(6,0)..(6,3); each triplet read_file, write_reg, write_file; then one done pulse.
REQ-040 Scenario: reset release, then no start -> all outputs 0 indefinitely.
REQ-041 Scenario: start re-pulsed at cycle 7 of a run -> run length unchanged and exactly one done pulse.
REQ-042 Scenario: rst=0 asynchronously mid-run at (6,2) -> outputs 0 before the next clk edge; a new start restarts at (5,0).
REQ-043 Scenario: start held high -> back-to-back runs separated by exactly one DONE cycle.
REQ-044 Scenario: with PERMUTE_CTRL_STALL_EN, stall=1 for 3 cycles in LOAD -> write_reg fires exactly once after release and the total run is 27 cycles.
